// File: rtl/core_featuremap_conv2d_kxk.sv
// Streaming KxK 2-D convolution: consumes one pixel column per accept and emits one saturated result per valid window.
// Optional build macro CONV2D_RELU_EN clamps negative results to zero before the output register.
module core_featuremap_conv2d_kxk #(
    parameter int DWIDTH = 32,
    parameter int KSIZE  = 3,
    parameter int IMG_W  = 32,
    parameter int FRAC   = 0
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DWIDTH*KSIZE-1:0]          ff_rdata,
    output logic                             ff_rdreq,
    input  logic                             ff_empty,
    output logic [DWIDTH-1:0]                ff_wdata,
    output logic                             ff_wrreq,
    input  logic                             ff_full,
    input  logic                             wt_wr,
    input  logic [$clog2(KSIZE*KSIZE)-1:0]   wt_addr,
    input  logic [DWIDTH-1:0]                wt_data
);

    localparam int NTAP = KSIZE * KSIZE;
    localparam int AW   = $clog2(NTAP);
    localparam int PW   = 2 * DWIDTH;
    localparam int SW   = PW + $clog2(NTAP);
    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_FILL = CW'(KSIZE - 1);

    localparam logic signed [SW-1:0] SAT_MAX = {{(SW-DWIDTH+1){1'b0}}, {(DWIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {{(SW-DWIDTH+1){1'b1}}, {(DWIDTH-1){1'b0}}};

    typedef enum logic {
        S_FILL = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           col_q, col_d;
    logic                    run_q;

    logic signed [DWIDTH-1:0] win_q [KSIZE][KSIZE];
    logic signed [DWIDTH-1:0] win_d [KSIZE][KSIZE];
    logic                     win_valid_q, win_valid_d;

    logic signed [DWIDTH-1:0] wt_q [NTAP];
    logic signed [DWIDTH-1:0] wt_d [NTAP];

    logic signed [PW-1:0]     prod_q [NTAP];
    logic signed [PW-1:0]     prod_d [NTAP];
    logic                     prod_valid_q, prod_valid_d;

    logic [DWIDTH-1:0]        out_q, out_d;
    logic                     out_valid_q, out_valid_d;

    logic                     stall;
    logic                     accept;
    logic                     fire;
    logic signed [SW-1:0]     sum;
    logic signed [SW-1:0]     shifted;
    logic [DWIDTH-1:0]        sat;

    assign stall    = out_valid_q && ff_full;
    assign ff_rdreq = run_q && !ff_empty && !stall;
    assign accept   = ff_rdreq;
    assign ff_wrreq = out_valid_q && !ff_full;
    assign ff_wdata = out_q;

    // run_q rises one edge after reset release, so the first edge never accepts a column.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        if (accept) begin
            if (col_q == COL_LAST) begin
                col_d   = '0;
                state_d = S_FILL;
            end else begin
                col_d = col_q + 1'b1;
                if (col_q == COL_FILL) begin
                    state_d = S_RUN;
                end
            end
        end
    end

    // The accept that completes the KSIZE-th column of a row already yields a full window.
    always_comb begin
        fire = accept && ((state_q == S_RUN) || (col_q == COL_FILL));
    end

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KSIZE-1] = ff_rdata[r*DWIDTH +: DWIDTH];
            end
        end
        win_valid_d = stall ? win_valid_q : fire;
    end

    always_comb begin
        wt_d = wt_q;
        if (wt_wr) begin
            for (int i = 0; i < NTAP; i++) begin
                if (wt_addr == AW'(i)) begin
                    wt_d[i] = wt_data;
                end
            end
        end
    end

    always_comb begin
        prod_d       = prod_q;
        prod_valid_d = prod_valid_q;
        if (!stall) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    prod_d[r*KSIZE+c] = PW'(win_q[r][c]) * PW'(wt_q[r*KSIZE+c]);
                end
            end
            prod_valid_d = win_valid_q;
        end
    end

    // Full-precision sum, arithmetic scale-down, then clamp to the signed output range.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NTAP; i++) begin
            sum = sum + SW'(prod_q[i]);
        end
        shifted = sum >>> FRAC;
        if (shifted > SAT_MAX) begin
            sat = SAT_MAX[DWIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            sat = SAT_MIN[DWIDTH-1:0];
        end else begin
            sat = shifted[DWIDTH-1:0];
        end
`ifdef CONV2D_RELU_EN
        if (sat[DWIDTH-1]) begin
            sat = '0;
        end
`endif
    end

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (!stall) begin
            out_valid_d = prod_valid_q;
            if (prod_valid_q) begin
                out_d = sat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
            for (int i = 0; i < NTAP; i++) begin
                wt_q[i]   <= '0;
                prod_q[i] <= '0;
            end
            win_valid_q  <= 1'b0;
            prod_valid_q <= 1'b0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            win_q        <= win_d;
            wt_q         <= wt_d;
            prod_q       <= prod_d;
            win_valid_q  <= win_valid_d;
            prod_valid_q <= prod_valid_d;
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_core_featuremap_conv2d_kxk.sv
// Self-checking bench for core_featuremap_conv2d_kxk (DWIDTH=16, KSIZE=3, IMG_W=5, FRAC=0).
// Upstream/downstream FIFOs are modelled with queues; expected results come from tables or a window-sum model.
module tb_core_featuremap_conv2d_kxk;

    localparam int DW   = 16;
    localparam int K    = 3;
    localparam int W    = 5;
    localparam int FRAC = 0;
    localparam int AW   = $clog2(K*K);
    localparam longint SMAX = (longint'(1) << (DW-1)) - 1;
    localparam longint SMIN = -(longint'(1) << (DW-1));

    typedef logic [DW*K-1:0] col_t;

    typedef struct {
        string         name;
        logic [DW-1:0] wt;
        logic [DW-1:0] px;
        logic [DW-1:0] exp;
    } vec_t;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [DW*K-1:0] ff_rdata = '0;
    logic           ff_rdreq;
    logic           ff_empty = 1'b1;
    logic [DW-1:0]  ff_wdata;
    logic           ff_wrreq;
    logic           ff_full = 1'b0;
    logic           wt_wr = 1'b0;
    logic [AW-1:0]  wt_addr = '0;
    logic [DW-1:0]  wt_data = '0;

    col_t          col_q[$];
    logic [DW-1:0] got_q[$];
    logic [DW-1:0] exp_q[$];
    int            acc_cyc[$];
    int            push_cyc[$];
    int            wts[K*K];
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            full_req = 1'b0;
    bit            hold_empty = 1'b0;
    bit            rand_bp = 1'b0;
    col_t          row_buf[W];
    vec_t          vecs[8];

    core_featuremap_conv2d_kxk #(
        .DWIDTH(DW), .KSIZE(K), .IMG_W(W), .FRAC(FRAC)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ff_rdata(ff_rdata),
        .ff_rdreq(ff_rdreq),
        .ff_empty(ff_empty),
        .ff_wdata(ff_wdata),
        .ff_wrreq(ff_wrreq),
        .ff_full (ff_full),
        .wt_wr   (wt_wr),
        .wt_addr (wt_addr),
        .wt_data (wt_data)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog");
    end

    // One clock cycle: drive FIFO-side inputs at negedge, then record the handshakes the next posedge will act on.
    task automatic applyStimulus();
        @(negedge clock);
        ff_empty = (col_q.size() == 0) || hold_empty;
        ff_rdata = (col_q.size() != 0) ? col_q[0] : '0;
        ff_full  = full_req;
        #1;
        if (ff_rdreq) begin
            void'(col_q.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (ff_wrreq) begin
            got_q.push_back(ff_wdata);
            push_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic checkOutput(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference: direct window sum over row columns x..x+K-1, then scale, saturate and optional clamp.
    function automatic logic [DW-1:0] conv_ref(input col_t cols[W], input int x);
        longint s;
        col_t cv;
        logic signed [DW-1:0] px;
        s = 0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                cv = cols[x+c];
                px = cv[r*DW +: DW];
                s += longint'(px) * longint'(wts[r*K+c]);
            end
        end
        s = s >>> FRAC;
        if (s > SMAX) s = SMAX;
        else if (s < SMIN) s = SMIN;
`ifdef CONV2D_RELU_EN
        if (s < 0) s = 0;
`endif
        return s[DW-1:0];
    endfunction

    task automatic write_weight(input int idx, input logic [DW-1:0] val);
        logic signed [DW-1:0] sv;
        wt_wr   = 1'b1;
        wt_addr = AW'(idx);
        wt_data = val;
        applyStimulus();
        wt_wr   = 1'b0;
        sv      = val;
        wts[idx] = int'(sv);
    endtask

    task automatic write_all_weights(input logic [DW-1:0] val);
        for (int i = 0; i < K*K; i++) write_weight(i, val);
    endtask

    task automatic fill_uniform_row(input logic [DW-1:0] px);
        for (int x = 0; x < W; x++) row_buf[x] = {K{px}};
    endtask

    task automatic add_row(input bit use_model);
        for (int x = 0; x < W; x++) col_q.push_back(row_buf[x]);
        if (use_model) begin
            for (int x = 0; x <= W-K; x++) exp_q.push_back(conv_ref(row_buf, x));
        end
    endtask

    task automatic push_exp(input logic [DW-1:0] v, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(v);
    endtask

    task automatic run_expect(input string name, input int budget);
        int i = 0;
        while (i < budget && !(col_q.size() == 0 && got_q.size() >= exp_q.size())) begin
            if (rand_bp) begin
                full_req   = ($urandom_range(0, 2) == 0);
                hold_empty = ($urandom_range(0, 3) == 0);
            end
            applyStimulus();
            i++;
        end
        full_req   = 1'b0;
        hold_empty = 1'b0;
        repeat (8) applyStimulus();
        checkOutput({name, "_count"}, got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            checkOutput($sformatf("%s_out%0d", name, j), got_q[j], exp_q[j]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int guard;
        int bad;
        logic [DW-1:0] rw;
        logic [DW-1:0] rp;

        vecs[0] = '{"ones",        16'h0001, 16'h0001, 16'h0009};
        vecs[1] = '{"sat_pos",     16'h7FFF, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{"pos_neg_neg", 16'h8000, 16'h8000, 16'h7FFF};
        vecs[3] = '{"zero_wt",     16'h0000, 16'h04D2, 16'h0000};
        vecs[4] = '{"neg_neg",     16'hFFFE, 16'hFFFB, 16'h005A};
`ifdef CONV2D_RELU_EN
        vecs[5] = '{"sat_neg",     16'h8000, 16'h7FFF, 16'h0000};
        vecs[6] = '{"minus_one",   16'hFFFF, 16'h0001, 16'h0000};
        vecs[7] = '{"small_neg",   16'h0002, 16'hFFFD, 16'h0000};
`else
        vecs[5] = '{"sat_neg",     16'h8000, 16'h7FFF, 16'h8000};
        vecs[6] = '{"minus_one",   16'hFFFF, 16'h0001, 16'hFFF7};
        vecs[7] = '{"small_neg",   16'h0002, 16'hFFFD, 16'hFFCA};
`endif

        // Reset with data waiting upstream: nothing may be requested or pushed.
        fill_uniform_row(16'h0001);
        add_row(1'b0);
        repeat (3) applyStimulus();
        checkOutput("reset_rdreq", ff_rdreq, 0);
        checkOutput("reset_wrreq", ff_wrreq, 0);
        checkOutput("reset_wdata", ff_wdata, 0);
        reset = 1'b1;
        #1;
        checkOutput("release_no_accept", ff_rdreq, 0);
        hold_empty = 1'b1;

        // All-ones row: three results of 9, first push three cycles after the third accept.
        write_all_weights(16'h0001);
        hold_empty = 1'b0;
        acc_cyc.delete();
        push_cyc.delete();
        push_exp(16'h0009, 3);
        run_expect("ones_row", 100);
        if (acc_cyc.size() >= 3 && push_cyc.size() >= 1)
            checkOutput("first_push_latency", push_cyc[0] - acc_cyc[2], 3);
        else
            checkOutput("first_push_latency", -1, 3);

        // Uniform-weight / uniform-pixel table.
        for (int v = 0; v < 8; v++) begin
            write_all_weights(vecs[v].wt);
            fill_uniform_row(vecs[v].px);
            add_row(1'b0);
            push_exp(vecs[v].exp, W-K+1);
            run_expect(vecs[v].name, 100);
        end

        // Two rows, only tap r=1,c=2 set: the newest column's middle pixel passes through.
        for (int i = 0; i < K*K; i++) write_weight(i, (i == 1*K+2) ? 16'h0001 : 16'h0000);
        for (int x = 0; x < W; x++) row_buf[x] = {K{16'(x+1)}};
        add_row(1'b0);
        add_row(1'b0);
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back(16'd3);
            exp_q.push_back(16'd4);
            exp_q.push_back(16'd5);
        end
        run_expect("two_rows", 100);

        // Randomised weights/pixels with random upstream gaps and downstream backpressure.
        rand_bp = 1'b1;
        for (int round = 0; round < 6; round++) begin
            for (int i = 0; i < K*K; i++) begin
                rw = (round < 3) ? DW'($urandom_range(0, 15)) - 16'd8 : DW'($urandom);
                write_weight(i, rw);
            end
            for (int rr = 0; rr < 2; rr++) begin
                for (int x = 0; x < W; x++) begin
                    for (int r = 0; r < K; r++) begin
                        rp = (round < 3) ? DW'($urandom_range(0, 255)) - 16'd128 : DW'($urandom);
                        row_buf[x][r*DW +: DW] = rp;
                    end
                end
                add_row(1'b1);
            end
            run_expect($sformatf("random%0d", round), 2000);
        end
        rand_bp = 1'b0;

        // Downstream full for ten cycles from the first result: no handshakes, then all results in order.
        write_all_weights(16'h0001);
        acc_cyc.delete();
        fill_uniform_row(16'h0001);
        add_row(1'b0);
        push_exp(16'h0009, 3);
        guard = 0;
        while (acc_cyc.size() < 3 && guard < 50) begin
            applyStimulus();
            guard++;
        end
        repeat (2) applyStimulus();
        full_req = 1'b1;
        bad = 0;
        repeat (10) begin
            applyStimulus();
            if (ff_rdreq || ff_wrreq) bad++;
        end
        checkOutput("stall_no_handshake", bad, 0);
        checkOutput("stall_nothing_pushed", got_q.size(), 0);
        full_req = 1'b0;
        run_expect("stall_release", 100);

        // Reset after the fourth accept of a row: in-flight results vanish, next row starts at column 0.
        acc_cyc.delete();
        for (int x = 0; x < 4; x++) col_q.push_back({K{16'h0001}});
        guard = 0;
        while (acc_cyc.size() < 4 && guard < 50) begin
            applyStimulus();
            guard++;
        end
        applyStimulus();
        reset = 1'b0;
        repeat (4) applyStimulus();
        reset = 1'b1;
        repeat (8) applyStimulus();
        checkOutput("midrow_reset_no_push", got_q.size(), 0);
        got_q.delete();
        write_all_weights(16'h0001);
        fill_uniform_row(16'h0001);
        add_row(1'b0);
        push_exp(16'h0009, 3);
        run_expect("after_reset_row", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/core_featuremap_conv2d_kxk.md
CORE_FEATUREMAP_CONV2D_KXK -- requirements
Module: core_featuremap_conv2d_kxk

Interface
REQ-001 Parameter DWIDTH, 32, signed pixel/weight/result width in bits.
REQ-002 Parameter KSIZE, 3, kernel height and width; legal range 2..7.
REQ-003 Parameter IMG_W, 32, input columns per image row; IMG_W >= KSIZE.
REQ-004 Parameter FRAC, 0, fractional bits; the accumulated sum is arithmetic-shifted right by FRAC.
REQ-005 clock  input  1  single clock; all state updates on the rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 ff_rdata  input  DWIDTH*KSIZE  one column of KSIZE vertically stacked pixels; lane r = bits [r*DWIDTH +: DWIDTH], lane 0 = top row.
REQ-008 ff_rdreq  output  1  pop request to the upstream show-ahead FIFO.
REQ-009 ff_empty  input  1  upstream FIFO empty.
REQ-010 ff_wdata  output  DWIDTH  convolution result.
REQ-011 ff_wrreq  output  1  push request to the downstream FIFO.
REQ-012 ff_full  input  1  downstream FIFO full.
REQ-013 wt_wr  input  1  weight write strobe.
REQ-014 wt_addr  input  clog2(KSIZE*KSIZE)  weight index r*KSIZE+c (c = 0 is the oldest column).
REQ-015 wt_data  input  DWIDTH  signed weight value.

Function
REQ-016 Column accept: ff_rdreq = !ff_empty && !stall; a column is accepted on each cycle where ff_rdreq is high.
REQ-017 stall = out_valid && ff_full; while stall is high, all pipeline registers, counters and state hold their values.
REQ-018 Window: on accept, the KSIZE x KSIZE window shifts one column older and the new column enters at c = KSIZE-1.
REQ-019 FSM states: FILL (fewer than KSIZE columns of the current row held) and RUN (window valid); reset state is FILL.
REQ-020 The column counter counts 0..IMG_W-1 per accept, wraps to 0 after IMG_W-1 and forces the state to FILL.
REQ-021 FILL -> RUN on the accept that makes the row's column count equal KSIZE.
REQ-022 In RUN every accept produces exactly one result; outputs per row = IMG_W-KSIZE+1.
REQ-023 Results never combine columns from two different rows.
REQ-024 Arithmetic: KSIZE*KSIZE signed products of width 2*DWIDTH are summed at full precision (2*DWIDTH + clog2(KSIZE*KSIZE) bits), then arithmetic-shifted right by FRAC.
REQ-025 The shifted sum saturates to the signed DWIDTH range [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
REQ-026 Pipeline: accept at cycle t, window at t+1, product registers at t+2, out register at t+3; out_valid and ff_wdata update at t+3 in the absence of stall.
REQ-027 ff_wrreq = out_valid && !ff_full; each result is pushed exactly once, and none is dropped or duplicated under backpressure.
REQ-028 A weight write takes effect on the product stage from the cycle after wt_wr.
REQ-029 A weight write concurrent with streaming is permitted but is not glitch-protected for in-flight results.
REQ-030 Simultaneous ff_empty deassertion and ff_full assertion: stall has priority and no accept occurs.

Reset
REQ-031 On reset low: ff_rdreq = 0, ff_wrreq = 0, ff_wdata = 0, out_valid = 0, state = FILL, column counter = 0, window = 0, pipeline valids = 0, all weights = 0.
REQ-032 Reset asserted mid-row discards every in-flight result; the first column accepted after release is treated as column 0.
REQ-033 Reset release is synchronised internally so that no accept occurs on the first clock edge after release.

Configuration
REQ-034 Macro CONV2D_RELU_EN, when defined, clamps negative saturated results to 0 before the out register.
REQ-035 When CONV2D_RELU_EN is undefined, saturated results pass unchanged, including negative values.

Verification (DWIDTH=16, KSIZE=3, IMG_W=5, FRAC=0)
REQ-036 All weights 1, 5 columns of all-1 pixels, ff_full=0 -> exactly 3 pushes of 0x0009; the first ff_wrreq occurs 3 cycles after the 3rd accept.
REQ-037 Same stimulus with ff_full=1 for 10 cycles after the first result -> ff_rdreq=0 and ff_wrreq=0 throughout; after release, 3 total pushes of 0x0009 in order.
REQ-038 All weights 0x7FFF, pixels 0x7FFF -> every output is 0x7FFF; weights 0x8000 with pixels 0x7FFF -> every output is 0x8000 (without ReLU).
REQ-039 All weights 0xFFFF (-1), pixels 1 -> output 0xFFF7 without CONV2D_RELU_EN and 0x0000 with it.
REQ-040 Two rows, pixels = column index + 1, weight c=2 row 1 only = 1, others 0 -> outputs 3,4,5,3,4,5 with no cross-row result.
REQ-041 Reset pulled low after the 4th accept of a row -> no ff_wrreq for that row's remainder; a fresh 5-column row yields exactly 3 results.
